// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated TX FIFO, a runtime baud
// divisor and selectable 1 or 2 stop bits. Bytes are buffered and sent as
// back-to-back frames, LSB first.
// Optional feature: define UART_TX_PARITY_EN to add the parity_odd port and a
// PARITY bit after the data bits (parity = ^data ^ parity_odd).
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_start,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_ready,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0]        LAST_BIT   = IW'(DATA_WIDTH - 1);
    localparam logic [AW:0]          FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;

    state_t                state;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [DIV_WIDTH-1:0]  div_lat;
    logic [DIV_WIDTH-1:0]  new_div;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         bit_idx;
    logic                  stop2_lat;
    logic                  stop_idx;
    logic                  bit_end;
    logic                  final_stop;
    logic                  frame_end;
    logic                  div_one;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // The FIFO accepts a byte only while it has room; the FSM pops whenever it
    // can start a frame (from IDLE, or directly at the end of the final stop bit).
    assign tx_ready      = (fifo_count != FULL_COUNT);
    assign push          = tx_start && tx_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign bit_end       = (baud_cnt == '0);
    assign final_stop    = stop2_lat ? stop_idx : 1'b1;
    assign frame_end     = (state == STOP) && bit_end && final_stop;
    assign pop           = fifo_nonempty && ((state == IDLE) || frame_end);
    assign new_div       = (baud_div == '0) ? DIV_ONE : baud_div;
    assign div_one       = (div_lat == DIV_ONE);
    assign tx_busy       = (state != IDLE);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the registered overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_overflow <= tx_start && !tx_ready;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: each bit lasts div_lat cycles; tx and tx_done are
    // registered, so tx_done is armed one cycle ahead of the last stop cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            baud_cnt  <= '0;
            div_lat   <= DIV_ONE;
            shreg     <= '0;
            bit_idx   <= '0;
            stop2_lat <= 1'b0;
            stop_idx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                shreg     <= mem[rd_ptr];
                div_lat   <= new_div;
                baud_cnt  <= new_div - 1'b1;
                stop2_lat <= stop2;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^mem[rd_ptr]) ^ parity_odd;
`endif
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
                tx        <= 1'b0;
                state     <= START;
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            tx       <= shreg[0];
                            bit_idx  <= '0;
                            baud_cnt <= div_lat - 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= div_lat - 1'b1;
                            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= parity_bit;
`else
                                state    <= STOP;
                                tx       <= 1'b1;
                                stop_idx <= 1'b0;
                                if (!stop2_lat && div_one) begin
                                    tx_done <= 1'b1;
                                end
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx      <= shreg[1];
                                shreg   <= shreg >> 1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                            baud_cnt <= div_lat - 1'b1;
                            if (!stop2_lat && div_one) begin
                                tx_done <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            if (final_stop) begin
                                state <= IDLE;
                                tx    <= 1'b1;
                            end else begin
                                stop_idx <= 1'b1;
                                baud_cnt <= div_lat - 1'b1;
                                if (div_one) begin
                                    tx_done <= 1'b1;
                                end
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                            if (final_stop && (baud_cnt == DIV_ONE)) begin
                                tx_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. Stimulus pushes the
// expected frame description into a queue; a negedge monitor decodes the
// serial line and checks every bit period, tx_done and tx_busy against it.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] baud_div;
    logic        stop2;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd;
`endif
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_overflow;
    logic [3:0]  fifo_count;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic       stop2;
        logic       par;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int ovf_cnt     = 0;
    int stray_done  = 0;

    // Monitor state
    bit          in_frame = 1'b0;
    exp_t        cur;
    logic [12:0] bits;
    int          nbits;
    int          bit_pos;
    int          cyc_in_bit;
    int          eff_div;
    int          bad_cycles;
    int          bad_done;
    int          bad_busy;

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(8),
        .DIV_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .baud_div   (baud_div),
        .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overflow(tx_overflow),
        .fifo_count (fifo_count)
    );

    // 10 ns clock and a cycle counter used to time frame starts
    always #5 clk = ~clk;

    // Cycle counter: value N during the cycle that starts at the N-th posedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive one push for a cycle; queue the frame it should produce when sent=1
    task automatic applyStimulus(input logic [7:0] data, input bit first, input int start_rel, input bit sent);
        exp_t e;
        tx_start = 1'b1;
        tx_data  = data;
        if (first) t0 = cyc;
        if (sent) begin
            e.data  = data;
            e.div   = int'(baud_div);
            e.stop2 = stop2;
`ifdef UART_TX_PARITY_EN
            e.par   = parity_odd;
`else
            e.par   = 1'b0;
`endif
            e.start = (start_rel >= 0) ? t0 + start_rel : -1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            if (exp_q.size() == 0 && !in_frame && tx_busy === 1'b0 && fifo_count == 4'd0)
                done = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        checkOutput({name, "_drained"}, {31'd0, done}, 32'd1);
    endtask

    // Count overflow pulses as they appear on the output
    always @(negedge clk) begin
        if (tx_overflow === 1'b1) ovf_cnt++;
    end

    // Frame monitor: detect start bit, pop the expected frame, check each bit period
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        bits  = '0;
                        nbits = 0;
                        bits[nbits] = 1'b0;
                        nbits++;
                        for (int i = 0; i < 8; i++) begin
                            bits[nbits] = cur.data[i];
                            nbits++;
                        end
`ifdef UART_TX_PARITY_EN
                        bits[nbits] = (^cur.data) ^ cur.par;
                        nbits++;
`endif
                        bits[nbits] = 1'b1;
                        nbits++;
                        if (cur.stop2) begin
                            bits[nbits] = 1'b1;
                            nbits++;
                        end
                        eff_div    = (cur.div == 0) ? 1 : cur.div;
                        bit_pos    = 0;
                        cyc_in_bit = 0;
                        bad_cycles = 0;
                        bad_done   = 0;
                        bad_busy   = 0;
                        in_frame   = 1'b1;
                        if (cur.start >= 0)
                            checkOutput($sformatf("start_cycle_%02h", cur.data), cyc, cur.start);
                    end
                end else if (tx_done === 1'b1) begin
                    stray_done++;
                end
            end
            if (in_frame) begin
                if (tx !== bits[bit_pos]) bad_cycles++;
                if (tx_done !== ((bit_pos == nbits - 1) && (cyc_in_bit == eff_div - 1))) bad_done++;
                if (tx_busy !== 1'b1) bad_busy++;
                cyc_in_bit++;
                if (cyc_in_bit == eff_div) begin
                    checkOutput($sformatf("frame_%02h_bit%0d_wrong_cycles(level %0d)", cur.data, bit_pos, bits[bit_pos]),
                                bad_cycles, 0);
                    cyc_in_bit = 0;
                    bad_cycles = 0;
                    bit_pos++;
                    if (bit_pos == nbits) begin
                        checkOutput($sformatf("frame_%02h_done_wrong_cycles", cur.data), bad_done, 0);
                        checkOutput($sformatf("frame_%02h_busy_low_cycles", cur.data), bad_busy, 0);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    // Hard stop in case the DUT or bench hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion by 500000 ns, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        baud_div = 16'd4;
        stop2    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", tx_busy, 0);
        checkOutput("reset_done", tx_done, 0);
        checkOutput("reset_overflow", tx_overflow, 0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_ready", tx_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 0xA5 frame at baud_div=4; a divisor change mid-frame must not apply
        applyStimulus(8'hA5, 1'b1, 2, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        baud_div = 16'd7;
        waitIdle("single_a5", 200);
        baud_div = 16'd4;
        @(posedge clk);
        #1;

        // Three back-to-back frames, 40 cycles apart with no gap
        applyStimulus(8'h01, 1'b1, 2, 1'b1);
        applyStimulus(8'h02, 1'b0, 42, 1'b1);
        applyStimulus(8'h03, 1'b0, 82, 1'b1);
        waitIdle("back_to_back", 300);

        // Fill the FIFO while the first frame is on the line; 9th push overflows
        baud_div = 16'd2;
        @(posedge clk);
        #1;
        applyStimulus(8'h10, 1'b1, 2, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre_fill_overflows", ovf_cnt, 0);
        for (int k = 1; k <= 8; k++)
            applyStimulus(8'(8'h1F + k), 1'b0, 2 + 20 * k, 1'b1);
        applyStimulus(8'hEE, 1'b0, -1, 1'b0);
        checkOutput("full_count", fifo_count, 8);
        checkOutput("full_ready", tx_ready, 0);
        @(negedge clk);
        #1;
        checkOutput("overflow_pulses", ovf_cnt, 1);
        waitIdle("fill", 400);
        checkOutput("after_fill_ready", tx_ready, 1);
        checkOutput("after_fill_overflows", ovf_cnt, 1);

        // Reset in the middle of the data bits of 0x5A with 0x77 still queued
        baud_div = 16'd4;
        @(posedge clk);
        #1;
        applyStimulus(8'h5A, 1'b1, 2, 1'b1);
        applyStimulus(8'h77, 1'b0, -1, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("pre_reset_count", fifo_count, 1);
        checkOutput("pre_reset_busy", tx_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checkOutput("midframe_reset_tx", tx, 1);
        checkOutput("midframe_reset_count", fifo_count, 0);
        checkOutput("midframe_reset_busy", tx_busy, 0);
        checkOutput("midframe_reset_ready", tx_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h3C, 1'b1, 2, 1'b1);
        waitIdle("after_reset", 200);

        // baud_div=0 behaves as 1; two stop bits give an 11-cycle frame
        baud_div = 16'd0;
        stop2    = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'hFF, 1'b1, 2, 1'b1);
        applyStimulus(8'h81, 1'b0, 13, 1'b1);
        waitIdle("div0_stop2", 100);
        stop2    = 1'b0;
        baud_div = 16'd4;

`ifdef UART_TX_PARITY_EN
        // Parity: 0xA5 has even weight, so the bit equals parity_odd; 22-cycle frames
        baud_div   = 16'd2;
        parity_odd = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(8'hA5, 1'b1, 2, 1'b1);
        waitIdle("parity_even", 100);
        parity_odd = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'hA5, 1'b1, 2, 1'b1);
        waitIdle("parity_odd", 100);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("stray_done_pulses", stray_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
